// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode sequencer: opcodes, FSM states,
// instruction field positions and the HALT encoding.
package fd_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_EQ  = 3'd6;
  localparam logic [2:0] OP_BR  = 3'd7;

  typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 13;
  localparam int RD_HI    = 12;
  localparam int RD_LO    = 11;
  localparam int RS_HI    = 10;
  localparam int RS_LO    = 9;
  localparam int RT_HI    = 8;
  localparam int RT_LO    = 7;
  localparam int BA_HI    = 5;
  localparam int BA_LO    = 0;
  localparam int HALT_BIT = 12;

  localparam logic [15:0] INSTR_HALT = 16'h1000;

  // HALT shares op 0 with NOP; bit 12 tells them apart
  function automatic logic is_halt(input logic [15:0] ir);
    return (ir[OP_HI:OP_LO] == OP_NOP) && ir[HALT_BIT];
  endfunction

  function automatic logic writes_rd(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// 4 x 8-bit register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear.
module regfile4x8
  import fd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);

  logic [7:0] regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/fetch_decode.sv
// Non-pipelined sequencer in front of the 8-bit ALU: FETCH -> EXEC -> WB,
// one instruction in flight, terminal HALT state.
module fetch_decode
  import fd_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic [5:0]  alu_baddr,
  input  logic [7:0]  alu_result,
  input  logic        alu_co,
  input  logic        alu_eq,
  input  logic        alu_branch,
  output logic [5:0]  pc,
  output logic        carry,
  output logic        halted
);

  state_t      state;
  logic [15:0] ir;
  logic [2:0]  ir_op;
  logic [7:0]  rd_a;
  logic [7:0]  rd_b;
  logic        rf_we;
  logic        unused_sig;

  assign ir_op     = ir[OP_HI:OP_LO];
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign rf_we     = (state == WB) && writes_rd(ir_op);

  // The EQ flag lives in the ALU; branch decisions use alu_branch only
  assign unused_sig = ^{alu_eq, ir[RS_HI:RT_LO], ir[6]};

  // Operands are read straight from the incoming word so they are registered
  // onto the ALU inputs at the same edge that loads IR
  regfile4x8 u_rf (
    .clk     (CLK),
    .rst_n   (RST_N),
    .we      (rf_we),
    .waddr   (ir[RD_HI:RD_LO]),
    .wdata   (alu_result),
    .raddr_a (imem_rdata[RS_HI:RS_LO]),
    .raddr_b (imem_rdata[RT_HI:RT_LO]),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_NOP;
      alu_baddr <= '0;
      carry     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            ir        <= imem_rdata;
            alu_a     <= rd_a;
            alu_b     <= rd_b;
            alu_op    <= imem_rdata[OP_HI:OP_LO];
            alu_baddr <= imem_rdata[BA_HI:BA_LO];
            state     <= EXEC;
          end
        end
        EXEC: state <= WB;
        WB: begin
          alu_op <= OP_NOP;
          if (is_halt(ir)) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            if (ir_op == OP_ADD || ir_op == OP_SUB) carry <= alu_co;
            pc    <= (ir_op == OP_BR && alu_branch) ? ir[BA_HI:BA_LO] : pc + 6'd1;
            state <= FETCH;
          end
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: a behavioural ALU, a table of directed vectors,
// hand-written corner sequences and random instructions against a model.
module tb_fetch_decode;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [5:0]  alu_baddr;
  logic [7:0]  alu_result;
  logic        alu_co, alu_eq, alu_branch;
  logic [5:0]  pc;
  logic        carry, halted;

  int checks = 0;
  int errors = 0;

  // reference architectural state
  logic [7:0] m_r [4];
  logic [5:0] m_pc;
  logic       m_carry, m_halted, m_eq;

  always #5 CLK = ~CLK;

  fetch_decode dut (
    .CLK(CLK), .RST_N(RST_N), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_baddr(alu_baddr), .alu_result(alu_result), .alu_co(alu_co),
    .alu_eq(alu_eq), .alu_branch(alu_branch), .pc(pc), .carry(carry), .halted(halted)
  );

  // Behavioural ALU: registered result and flags, EQ flag held until next EQ
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_result <= '0; alu_co <= 1'b0; alu_eq <= 1'b0; alu_branch <= 1'b0;
    end else begin
      alu_branch <= (alu_op == 3'd7) && alu_eq;
      case (alu_op)
        3'd1: {alu_co, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
        3'd2: begin alu_result <= alu_a - alu_b; alu_co <= (alu_a < alu_b); end
        3'd3: alu_result <= alu_a & alu_b;
        3'd4: alu_result <= ~alu_a;
        3'd5: alu_result <= alu_a | alu_b;
        3'd6: alu_eq <= (alu_a == alu_b);
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [15:0] instr;
    int          wt;
    logic [5:0]  pc;
    int          reg_i;
    logic [7:0]  reg_v;
    logic        carry;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [15:0] enc(input int op, input int rd, input int rs,
                                      input int rt, input int ba);
    logic [2:0] o; logic [1:0] d, s, t; logic [5:0] b;
    o = op[2:0]; d = rd[1:0]; s = rs[1:0]; t = rt[1:0]; b = ba[5:0];
    return {o, d, s, t, 1'b0, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic [15:0] ins);
    logic [2:0] op; logic [7:0] a, b; logic [8:0] s; int rd;
    op = ins[15:13]; rd = int'(ins[12:11]);
    a = m_r[ins[10:9]]; b = m_r[ins[8:7]];
    case (op)
      3'd1: begin s = {1'b0, a} + {1'b0, b}; m_r[rd] = s[7:0]; m_carry = s[8]; end
      3'd2: begin m_r[rd] = a - b; m_carry = (a < b); end
      3'd3: m_r[rd] = a & b;
      3'd4: m_r[rd] = ~a;
      3'd5: m_r[rd] = a | b;
      3'd6: m_eq = (a == b);
      default: ;
    endcase
    if (op == 3'd0 && ins[12]) m_halted = 1'b1;
    else if (op == 3'd7 && m_eq) m_pc = ins[5:0];
    else m_pc = m_pc + 6'd1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    m_pc = '0; m_carry = 1'b0; m_halted = 1'b0; m_eq = 1'b0;
  endtask

  task automatic check_arch(input string tag);
    for (int i = 0; i < 4; i++) check({tag, "_reg"}, dut.u_rf.regs[i], m_r[i]);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_carry"}, carry, m_carry);
    check({tag, "_halted"}, halted, m_halted);
    check({tag, "_req"}, imem_req, !m_halted);
  endtask

  task automatic do_reset();
    imem_valid = 1'b1;
    imem_rdata = enc(4, 1, 0, 0, 0);
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 imem_valid = 1'b0;
    RST_N = 1'b1;
    model_reset();
    check("rst_req", imem_req, 1'b1);
    check("rst_addr", imem_addr, 6'd0);
    check("rst_alu", {alu_a, alu_b, alu_op, alu_baddr}, '0);
    check_arch("rst");
  endtask

  // Entered #1 after an edge with the DUT in FETCH
  task automatic run_instr(input logic [15:0] ins, input int wt, input bit noise);
    logic [7:0] ea, eb; logic [5:0] addr0;
    ea = m_r[ins[10:9]]; eb = m_r[ins[8:7]]; addr0 = m_pc;
    imem_valid = 1'b0;
    for (int i = 0; i < wt; i++) begin
      check("wait_req", imem_req, 1'b1);
      check("wait_addr", imem_addr, addr0);
      @(posedge CLK); #1;
    end
    check("fetch_addr", imem_addr, addr0);
    imem_valid = 1'b1; imem_rdata = ins;
    @(posedge CLK); #1;
    if (noise) imem_rdata = 16'($urandom); else imem_valid = 1'b0;
    check("exec_req", imem_req, 1'b0);
    check("exec_op", alu_op, ins[15:13]);
    check("exec_ab", {alu_a, alu_b}, {ea, eb});
    check("exec_baddr", alu_baddr, ins[5:0]);
    @(posedge CLK); #1;
    check("wb_req", imem_req, 1'b0);
    check("wb_hold", {alu_op, alu_a, alu_b, alu_baddr}, {ins[15:13], ea, eb, ins[5:0]});
    @(posedge CLK); #1;
    imem_valid = 1'b0;
    model_apply(ins);
    check("post_op", alu_op, 3'd0);
    check("post_ab", {alu_a, alu_b}, {ea, eb});
    check_arch("post");
  endtask

  initial begin
    logic [5:0] hpc; logic [15:0] ins; logic [7:0] ha;
    RST_N = 1'b0; imem_valid = 1'b0; imem_rdata = '0;

    tbl[0]  = '{enc(1,1,0,0,0),    0, 6'd1,  1, 8'h00, 1'b0};
    tbl[1]  = '{enc(4,1,0,0,0),    1, 6'd2,  1, 8'hFF, 1'b0};
    tbl[2]  = '{enc(2,2,0,1,0),    0, 6'd3,  2, 8'h01, 1'b1};
    tbl[3]  = '{enc(1,2,2,2,0),    2, 6'd4,  2, 8'h02, 1'b0};
    tbl[4]  = '{enc(1,3,2,2,0),    0, 6'd5,  3, 8'h04, 1'b0};
    tbl[5]  = '{enc(1,3,3,3,0),    0, 6'd6,  3, 8'h08, 1'b0};
    tbl[6]  = '{enc(1,3,3,3,0),    0, 6'd7,  3, 8'h10, 1'b0};
    tbl[7]  = '{enc(1,1,3,2,0),    0, 6'd8,  1, 8'h12, 1'b0};
    tbl[8]  = '{enc(4,3,0,0,0),    0, 6'd9,  3, 8'hFF, 1'b0};
    tbl[9]  = '{enc(2,3,0,3,0),    0, 6'd10, 3, 8'h01, 1'b1};
    tbl[10] = '{enc(1,2,2,3,0),    0, 6'd11, 2, 8'h03, 1'b0};
    tbl[11] = '{enc(1,3,1,2,0),    0, 6'd12, 3, 8'h15, 1'b0};
    tbl[12] = '{enc(4,1,0,0,0),    0, 6'd13, 1, 8'hFF, 1'b0};
    tbl[13] = '{enc(4,2,0,0,0),    0, 6'd14, 2, 8'hFF, 1'b0};
    tbl[14] = '{enc(1,3,1,2,0),    0, 6'd15, 3, 8'hFE, 1'b1};
    tbl[15] = '{enc(6,0,1,2,0),    0, 6'd16, 0, 8'h00, 1'b1};
    tbl[16] = '{enc(7,0,0,0,6'h24),0, 6'h24, 3, 8'hFE, 1'b1};
    tbl[17] = '{enc(6,0,1,3,0),    1, 6'h25, 1, 8'hFF, 1'b1};
    tbl[18] = '{enc(7,0,0,0,6'h2C),0, 6'h26, 3, 8'hFE, 1'b1};

    do_reset();
    foreach (tbl[i]) begin
      run_instr(tbl[i].instr, tbl[i].wt, 1'b0);
      check($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      check($sformatf("tbl%0d_reg", i), dut.u_rf.regs[tbl[i].reg_i], tbl[i].reg_v);
      check($sformatf("tbl%0d_carry", i), carry, tbl[i].carry);
    end

    // Branch to 63, then NOP with a 4-cycle fetch wait wraps pc to 0
    run_instr(enc(6,0,0,0,0), 0, 1'b0);
    run_instr(enc(7,0,0,0,6'h3F), 0, 1'b0);
    check("pc63", pc, 6'h3F);
    run_instr(enc(0,0,0,0,0), 4, 1'b0);
    check("pc_wrap", pc, 6'd0);

    // HALT: terminal, ignores fetch strobes, nothing moves
    run_instr(16'h1000, 0, 1'b0);
    hpc = pc; ha = alu_a;
    check("halt_flag", halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      imem_valid = 1'($urandom); imem_rdata = enc(4,1,0,0,0);
      @(posedge CLK); #1;
      check("halt_req", imem_req, 1'b0);
      check("halt_pc", pc, hpc);
      check("halt_alu", {alu_op, alu_a}, {3'd0, ha});
    end
    imem_valid = 1'b0;

    // Reset pulsed during WB of NOT r1: no write, no pc update
    do_reset();
    run_instr(enc(1,2,0,0,0), 0, 1'b0);
    imem_valid = 1'b1; imem_rdata = enc(4,1,0,0,0);
    @(posedge CLK); #1;
    imem_valid = 1'b0;
    @(posedge CLK); #1;
    check("wbrst_inwb", imem_req, 1'b0);
    RST_N = 1'b0;
    #2;
    check("wbrst_r1", dut.u_rf.regs[1], 8'h00);
    check("wbrst_pc", pc, 6'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_reset();
    check("wbrst_fetch", imem_req, 1'b1);
    check_arch("wbrst");
    run_instr(enc(4,3,0,0,0), 0, 1'b0);

    // Random instruction stream against the model
    do_reset();
    for (int n = 0; n < 200; n++) begin
      ins = 16'($urandom);
      if (ins[15:13] == 3'd0) ins[12] = 1'b0;
      run_instr(ins, $urandom_range(0, 3), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
